// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared FC DMA widths, layer weight bases and FSM state encoding
package fc_pkg;

    localparam int FC_MEM_ADDRESS_WIDTH   = 16;
    localparam int FC_LAYER_ADDRESS_WIDTH = 7;
    localparam int FC_DATA_WIDTH          = 16;

    // Each F6 neuron burst is one bias plus 120 weights; the output layer follows F6's 84 neurons
    localparam int F6_BURST_WORDS = 121;
    localparam int F6_NEURONS     = 84;

    localparam logic [FC_MEM_ADDRESS_WIDTH-1:0] F6_WEIGHT_BASE  = '0;
    localparam logic [FC_MEM_ADDRESS_WIDTH-1:0] OUT_WEIGHT_BASE =
        FC_MEM_ADDRESS_WIDTH'(F6_BURST_WORDS * F6_NEURONS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } dma_state_t;

endpackage

// File: rtl/fc_dma_buffer.sv
// rtl/fc_dma_buffer.sv - burst staging RAM, one write port and one registered read port
module fc_dma_buffer #(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDRESS_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fc_dma.sv
// rtl/fc_dma.sv - buffers one weight burst from memory, then streams it onto the FC data bus
module fc_dma
    import fc_pkg::*;
#(
    parameter int MEM_ADDRESS_WIDTH   = FC_MEM_ADDRESS_WIDTH,
    parameter int LAYER_ADDRESS_WIDTH = FC_LAYER_ADDRESS_WIDTH,
    parameter int DATA_WIDTH          = FC_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_en,
    input  logic                           DMA_read,
    input  logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address,
    input  logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count,
    output logic                           DMA_ready,
    output logic                           mem_read,
    output logic [MEM_ADDRESS_WIDTH-1:0]   mem_address,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    output logic                           out_last
);

    dma_state_t                     state, state_next;
    logic [MEM_ADDRESS_WIDTH-1:0]   base, base_next;
    logic [LAYER_ADDRESS_WIDTH-1:0] len, len_next;
    logic [LAYER_ADDRESS_WIDTH-1:0] cnt, cnt_next;

    logic                           capture;
    logic [LAYER_ADDRESS_WIDTH-1:0] buf_rd_addr;
    logic [DATA_WIDTH-1:0]          buf_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            len   <= '0;
            cnt   <= '0;
        end else if (clk_en) begin
            state <= state_next;
            base  <= base_next;
            len   <= len_next;
            cnt   <= cnt_next;
        end
    end

    // In FETCH, cnt is the next address offset to issue; in STREAM it is the word on the bus
    always_comb begin
        state_next  = state;
        base_next   = base;
        len_next    = len;
        cnt_next    = cnt;
        capture     = 1'b0;
        buf_rd_addr = cnt + 1'b1;
        case (state)
            IDLE: begin
                if (DMA_read && (DMA_count != '0)) begin
                    base_next  = DMA_address;
                    len_next   = DMA_count;
                    cnt_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                capture = (cnt != '0);
                if (cnt == len) begin
                    cnt_next   = '0;
                    state_next = READY;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                buf_rd_addr = '0;
                cnt_next    = '0;
                state_next  = STREAM;
            end
            STREAM: begin
                if (cnt == len - 1'b1) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word i-1 arrives from memory one enabled cycle after its address was issued
    fc_dma_buffer #(
        .ADDRESS_WIDTH (LAYER_ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (clk_en && !rst && capture),
        .wr_addr (cnt - 1'b1),
        .wr_data (mem_data),
        .rd_en   (clk_en),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    // Outputs decode registered state only, so they hold while clk_en is low
    always_comb begin
        mem_read    = (state == FETCH) && (cnt != len);
        mem_address = mem_read ? base + MEM_ADDRESS_WIDTH'(cnt) : '0;
        DMA_ready   = (state == READY);
        out_valid   = (state == STREAM);
        out_last    = out_valid && (cnt == len - 1'b1);
        out_data    = out_valid ? buf_rd_data : '0;
    end

endmodule

// File: doc/fc_dma.md
FC_DMA -- requirements
Module: fc_dma

Interface
REQ-001 SHALL have parameter MEM_ADDRESS_WIDTH, default 16, word address width of weight memory.
REQ-002 SHALL have parameter LAYER_ADDRESS_WIDTH, default 7, width of burst count and buffer index (buffer depth 2^LAYER_ADDRESS_WIDTH).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, width of one bias/weight word.
REQ-004 SHALL have port clk  in  1  the only clock; rising-edge logic only.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port clk_en  in  1  global clock enable; no state changes when low.
REQ-007 SHALL have port DMA_read  in  1  level request from FC controller.
REQ-008 SHALL have port DMA_address  in  MEM_ADDRESS_WIDTH  first word address of burst.
REQ-009 SHALL have port DMA_count  in  LAYER_ADDRESS_WIDTH  words in burst (bias + weights).
REQ-010 SHALL have port DMA_ready  out  1  one-cycle pulse: burst buffered, streaming starts next cycle.
REQ-011 SHALL have port mem_read  out  1  weight memory read strobe.
REQ-012 SHALL have port mem_address  out  MEM_ADDRESS_WIDTH  weight memory address.
REQ-013 SHALL have port mem_data  in  DATA_WIDTH  memory read data, valid one enabled cycle after mem_read.
REQ-014 SHALL have port out_data  out  DATA_WIDTH  streamed word onto FC data bus.
REQ-015 SHALL have port out_valid  out  1  out_data holds a burst word.
REQ-016 SHALL have port out_last  out  1  qualifies final word of burst.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, READY, STREAM; every transition and register update gated by clk_en.
REQ-018 IDLE: when DMA_read=1 and DMA_count!=0, SHALL latch DMA_address and DMA_count into base/len registers and go to FETCH; DMA_count=0 SHALL be ignored (stay IDLE).
REQ-019 FETCH: SHALL assert mem_read with mem_address=base+i for i=0..len-1, one per enabled cycle, address arithmetic modulo 2^MEM_ADDRESS_WIDTH (wraps, no error).
REQ-020 FETCH: SHALL write mem_data into buffer slot i-1 on the enabled cycle after issuing address i-1; mem_read SHALL be 0 on the capture-only final cycle.
REQ-021 SHALL enter READY on the cycle after the last word is captured; READY lasts exactly one enabled cycle with DMA_ready=1, then STREAM.
REQ-022 STREAM: SHALL drive buffer[j], j=0..len-1, one word per enabled cycle with out_valid=1; out_last=1 only when j=len-1; then IDLE.
REQ-023 Fetch latency: DMA_ready SHALL rise len+1 enabled cycles after the IDLE cycle that accepted the request; a 121-word burst takes 121+1+1+121 enabled cycles from accept to return to IDLE.
REQ-024 DMA_address/DMA_count changes outside IDLE SHALL be ignored; the next request is sampled only on returning to IDLE (the controller reprograms the address on the DMA_ready cycle).
REQ-025 DMA_read dropping to 0 mid-burst SHALL NOT abort the burst.
REQ-026 When clk_en=0 all outputs SHALL hold their values; the memory is clk_en-gated identically so mem_data alignment is preserved.
REQ-027 Outside STREAM, out_valid and out_last SHALL be 0 and out_data SHALL be 0.
REQ-028 len=1: SHALL fetch one word, pulse DMA_ready, stream one word with out_valid=1 and out_last=1 together.

Reset
REQ-029 On rst=1 at a rising edge (regardless of clk_en) SHALL go to IDLE and clear DMA_ready, mem_read, mem_address, out_data, out_valid, out_last, base, len and counters to 0; buffer contents undefined.
REQ-030 Reset mid-FETCH or mid-STREAM SHALL abort the burst with no further DMA_ready or out_valid until a new request.

Structure
REQ-031 Shared package fc_pkg SHALL hold the FSM state encoding, default widths and layer base addresses (F6 at 0, output layer at 121*84).
REQ-032 Buffer SHALL be sub-module fc_dma_buffer: one write port, one registered-read port, depth 2^LAYER_ADDRESS_WIDTH, DATA_WIDTH wide, no reset.

Verification
REQ-033 rst pulse, then DMA_read=1, address=0, count=121, memory word k=k -> 121 consecutive mem_read addresses 0..120, one DMA_ready pulse, then out_data 0..120 with out_last on 120.
REQ-034 address=0xFFFE, count=4 -> mem_address sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; streamed data matches.
REQ-035 count=1, memory[10164]=0x1234 -> DMA_ready pulse, single out_data 0x1234 with out_valid=out_last=1.
REQ-036 clk_en toggled 50% randomly during a count=85 burst -> identical data/order to clk_en=1 run; no duplicated or dropped words.
REQ-037 rst asserted at FETCH word 40 of 121 -> IDLE next cycle, all outputs 0, no DMA_ready; new request afterwards completes correctly.
REQ-038 count=0 request, and DMA_address changed during STREAM -> no memory activity for count=0; next burst uses address present on the IDLE sampling cycle.
